// File: rtl/hs_utils_pkg.sv
// Shared handshake-buffer types and sizing helpers.
package hs_utils_pkg;

    typedef enum logic {
        HS_BUF_REGISTERED  = 1'b0,
        HS_BUF_FALLTHROUGH = 1'b1
    } hs_buf_mode_e;

    // Width needed to hold an occupancy value in 0..depth.
    function automatic int hs_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hs_buf_mem.sv
// Storage for hs_skid_fifo: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the owner's count.
module hs_buf_mem #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                     clk_core,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk_core) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hs_skid_fifo.sv
// Elastic ready/valid buffer of DEPTH entries with optional fall-through when empty.
// in_ready is derived from registered count (plus flush), so no out_ready->in_ready path.
module hs_skid_fifo
    import hs_utils_pkg::*;
#(
    parameter int           WIDTH    = 1,
    parameter int           DEPTH    = 2,
    parameter hs_buf_mode_e MODE     = HS_BUF_FALLTHROUGH,
    parameter int           AF_LEVEL = DEPTH - 1
) (
    input  logic                           clk_core,
    input  logic                           rst_core_n,
    input  logic                           flush_req,
    output logic                           stall,
    input  logic [WIDTH-1:0]               in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [hs_cnt_w(DEPTH)-1:0]     count,
    output logic                           almost_full
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = hs_cnt_w(DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_C    = CW'(AF_LEVEL);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hs_skid_fifo: DEPTH must be a power of two and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("hs_skid_fifo: AF_LEVEL must be in 1..DEPTH");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             pass_thru;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             wr_en;
    logic             rd_adv;
    logic [CW-1:0]    count_nxt;

    assign empty     = (count == '0);
    assign pass_thru = (MODE == HS_BUF_FALLTHROUGH) && empty;
    assign in_ready  = (count != DEPTH_C) & ~flush_req;
    assign stall     = ~in_ready;

    // Output mux: bypass input directly when empty in fall-through mode, else head of storage.
    always_comb begin
        out       = rd_data;
        out_valid = ~empty & ~flush_req;
        if (pass_thru) begin
            out       = in;
            out_valid = in_valid & ~flush_req;
        end
    end

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // A bypassed beat goes straight through and never touches storage or pointers.
    assign bypass    = pass_thru & push & pop;
    assign wr_en     = push & ~bypass & rst_core_n;
    assign rd_adv    = pop & ~bypass;
    assign count_nxt = count + CW'(wr_en) - CW'(rd_adv);

    hs_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_core (clk_core),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr),
        .wr_data  (in),
        .rd_addr  (rd_ptr),
        .rd_data  (rd_data)
    );

    // Pointer, occupancy and almost_full registers; reset and flush both empty the buffer.
    always_ff @(posedge clk_core) begin
        if (!rst_core_n || flush_req) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
            if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
            count       <= count_nxt;
            almost_full <= (count_nxt >= AF_C);
        end
    end

endmodule

// File: tb/tb_hs_skid_fifo.sv
// Bench for hs_skid_fifo: three instances (fall-through D4, registered D4, registered D2)
// share one stimulus stream; an array-based FIFO model predicts each instance.
module tb_hs_skid_fifo;
    import hs_utils_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] din;
    logic       vin;
    logic       ordy;

    logic [7:0] o0, o1, o2;
    logic       ov0, ov1, ov2, ir0, ir1, ir2, st0, st1, st2, af0, af1, af2;
    logic [2:0] c0, c1;
    logic [1:0] c2;

    logic [7:0] obs_out [3];
    logic       obs_ov [3], obs_ir [3], obs_st [3], obs_af [3];
    logic [2:0] obs_cnt [3];

    int  dep [3] = '{4, 4, 2};
    bit  ft  [3] = '{1'b1, 1'b0, 1'b0};
    int  afl [3] = '{3, 3, 1};
    logic [7:0] mbuf [3][4];
    int  msz [3];

    int npass = 0;
    int nchk  = 0;

    always #5 clk = ~clk;

    hs_skid_fifo #(.WIDTH(8), .DEPTH(4), .MODE(HS_BUF_FALLTHROUGH), .AF_LEVEL(3)) dut_ft4 (
        .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush), .stall(st0), .in(din),
        .in_valid(vin), .in_ready(ir0), .out(o0), .out_valid(ov0), .out_ready(ordy),
        .count(c0), .almost_full(af0));

    hs_skid_fifo #(.WIDTH(8), .DEPTH(4), .MODE(HS_BUF_REGISTERED)) dut_rg4 (
        .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush), .stall(st1), .in(din),
        .in_valid(vin), .in_ready(ir1), .out(o1), .out_valid(ov1), .out_ready(ordy),
        .count(c1), .almost_full(af1));

    hs_skid_fifo #(.WIDTH(8), .DEPTH(2), .MODE(HS_BUF_REGISTERED)) dut_rg2 (
        .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush), .stall(st2), .in(din),
        .in_valid(vin), .in_ready(ir2), .out(o2), .out_valid(ov2), .out_ready(ordy),
        .count(c2), .almost_full(af2));

    always_comb begin
        obs_out[0] = o0;  obs_out[1] = o1;  obs_out[2] = o2;
        obs_ov[0]  = ov0; obs_ov[1]  = ov1; obs_ov[2]  = ov2;
        obs_ir[0]  = ir0; obs_ir[1]  = ir1; obs_ir[2]  = ir2;
        obs_st[0]  = st0; obs_st[1]  = st1; obs_st[2]  = st2;
        obs_af[0]  = af0; obs_af[1]  = af1; obs_af[2]  = af2;
        obs_cnt[0] = c0;  obs_cnt[1] = c1;  obs_cnt[2] = {1'b0, c2};
    end

    // Advance one clock and apply the FIFO rules to the model using the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            int n;
            bit push, ov, pop;
            n = msz[i];
            if (!rst_n || flush) begin
                msz[i] = 0;
            end else begin
                push = vin && (n != dep[i]);
                ov   = (ft[i] && n == 0) ? vin : (n != 0);
                pop  = ov && ordy;
                if (!(ft[i] && n == 0 && push && pop)) begin
                    if (pop) begin
                        for (int k = 0; k < 3; k++) mbuf[i][k] = mbuf[i][k+1];
                        n--;
                    end
                    if (push) begin
                        mbuf[i][n] = din;
                        n++;
                    end
                end
                msz[i] = n;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; vin = 1'b1; din = 8'h0A; ordy = 1'b0;
        tick();
        @(negedge clk);
        nchk++; if (c0 !== 3'd0) $display("FAIL reset_count got %0d want 0", c0); else npass++;
        nchk++; if (ir0 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir0); else npass++;
        nchk++; if (st0 !== 1'b0) $display("FAIL reset_stall got %b want 0", st0); else npass++;
        nchk++; if (af0 !== 1'b0) $display("FAIL reset_almost_full got %b want 0", af0); else npass++;
        nchk++; if (o0 !== 8'h0A || ov0 !== 1'b1) $display("FAIL reset_fallthrough got %h/%b want 0a/1", o0, ov0); else npass++;
        nchk++; if (ov1 !== 1'b0) $display("FAIL reset_reg_out_valid got %b want 0", ov1); else npass++;
        tick();
        rst_n = 1'b1; vin = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        ordy = 1'b1; flush = 1'b0;
        for (int v = 1; v <= 8; v++) begin
            vin = 1'b1; din = 8'(v);
            @(negedge clk);
            nchk++; if (o0 !== 8'(v) || ov0 !== 1'b1) $display("FAIL bypass_out got %h/%b want %h/1", o0, ov0, v); else npass++;
            nchk++; if (c0 !== 3'd0) $display("FAIL bypass_count got %0d want 0", c0); else npass++;
            tick();
        end
        vin = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        flush = 1'b1; tick(); flush = 1'b0;
        ordy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            vin = 1'b1; din = 8'(k);
            @(negedge clk);
            nchk++; if (ir0 !== (k <= 4)) $display("FAIL fill_in_ready beat %0d got %b want %b", k, ir0, (k <= 4)); else npass++;
            nchk++; if (c0 !== 3'((k > 4) ? 4 : k - 1)) $display("FAIL fill_count beat %0d got %0d", k, c0); else npass++;
            nchk++; if (af0 !== (k >= 4)) $display("FAIL fill_almost_full beat %0d got %b want %b", k, af0, (k >= 4)); else npass++;
            tick();
        end
        vin = 1'b0; ordy = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            nchk++; if (o0 !== 8'(e) || ov0 !== 1'b1) $display("FAIL drain_out got %h/%b want %h/1", o0, ov0, e); else npass++;
            if (e == 1) begin
                nchk++; if (ir0 !== 1'b0) $display("FAIL full_pop_in_ready got %b want 0", ir0); else npass++;
            end
            tick();
        end
        for (int e = 5; e <= 6; e++) begin
            vin = 1'b1; din = 8'(e);
            @(negedge clk);
            nchk++; if (o0 !== 8'(e) || ov0 !== 1'b1) $display("FAIL tail_out got %h/%b want %h/1", o0, ov0, e); else npass++;
            tick();
        end
        vin = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_registered();
        flush = 1'b1; tick(); flush = 1'b0;
        ordy = 1'b1; vin = 1'b1; din = 8'h03;
        @(negedge clk);
        nchk++; if (ov2 !== 1'b0) $display("FAIL reg_first_valid got %b want 0", ov2); else npass++;
        tick();
        vin = 1'b0;
        @(negedge clk);
        nchk++; if (ov2 !== 1'b1 || o2 !== 8'h03) $display("FAIL reg_latency got %h/%b want 03/1", o2, ov2); else npass++;
        tick();
        for (int k = 0; k < 10; k++) begin
            vin = 1'b1; din = 8'(8'h10 + k);
            @(negedge clk);
            nchk++; if (ir2 !== 1'b1) $display("FAIL reg_stream_ready cycle %0d got %b want 1", k, ir2); else npass++;
            if (k > 0) begin
                nchk++; if (ov2 !== 1'b1 || o2 !== 8'(8'h10 + k - 1)) $display("FAIL reg_stream_out cycle %0d got %h/%b want %h/1", k, o2, ov2, 8'h10 + k - 1); else npass++;
            end
            tick();
        end
        vin = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_flush();
        flush = 1'b1; tick(); flush = 1'b0;
        ordy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            vin = 1'b1; din = 8'(k); tick();
        end
        vin = 1'b0;
        @(negedge clk);
        nchk++; if (c1 !== 3'd3) $display("FAIL flush_precount got %0d want 3", c1); else npass++;
        flush = 1'b1; vin = 1'b1; ordy = 1'b1; din = 8'h55;
        @(negedge clk);
        nchk++; if (ir1 !== 1'b0 || ov1 !== 1'b0) $display("FAIL flush_no_handshake got ir=%b ov=%b want 0/0", ir1, ov1); else npass++;
        tick();
        flush = 1'b0; vin = 1'b0;
        @(negedge clk);
        nchk++; if (c1 !== 3'd0 || ov1 !== 1'b0 || ir1 !== 1'b1) $display("FAIL flush_after got cnt=%0d ov=%b ir=%b want 0/0/1", c1, ov1, ir1); else npass++;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int rdy_pct;
            rdy_pct = ((cyc / 400) % 3 == 0) ? 20 : (((cyc / 400) % 3 == 1) ? 90 : 50);
            vin   = ($urandom_range(0, 99) < 65);
            ordy  = ($urandom_range(0, 99) < rdy_pct);
            flush = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            din   = 8'($urandom);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int  n;
                bit  e_ir, e_ov;
                logic [7:0] e_out;
                n     = msz[i];
                e_ir  = (n != dep[i]) && !flush;
                if (ft[i] && n == 0) begin
                    e_ov = vin && !flush; e_out = din;
                end else begin
                    e_ov = (n != 0) && !flush; e_out = mbuf[i][0];
                end
                nchk++; if (obs_cnt[i] !== 3'(n)) $display("FAIL rnd_count dut%0d cyc %0d got %0d want %0d", i, cyc, obs_cnt[i], n); else npass++;
                nchk++; if (obs_af[i] !== (n >= afl[i])) $display("FAIL rnd_almost_full dut%0d cyc %0d got %b want %b", i, cyc, obs_af[i], (n >= afl[i])); else npass++;
                nchk++; if (obs_ir[i] !== e_ir || obs_st[i] !== !e_ir) $display("FAIL rnd_ready dut%0d cyc %0d got ir=%b st=%b want ir=%b", i, cyc, obs_ir[i], obs_st[i], e_ir); else npass++;
                nchk++; if (obs_ov[i] !== e_ov) $display("FAIL rnd_out_valid dut%0d cyc %0d got %b want %b", i, cyc, obs_ov[i], e_ov); else npass++;
                if (e_ov) begin
                    nchk++; if (obs_out[i] !== e_out) $display("FAIL rnd_out dut%0d cyc %0d got %h want %h", i, cyc, obs_out[i], e_out); else npass++;
                end
            end
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; vin = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) msz[i] = 0;
        test_reset();
        test_bypass();
        test_backpressure();
        test_registered();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/hs_skid_fifo.md
# hs_skid_fifo

Parametrised elastic buffer for ready/valid pipeline stages, generalising the two-entry skid register to DEPTH entries. It offers a selectable zero-latency fall-through mode and exposes occupancy. `in_ready` depends only on registered state, which breaks the combinational ready path between stages. It supports a synchronous pipeline flush. The block sits between core pipeline stages and on decoupling points such as fetch→decode and memory response queues.

## Interface
- `WIDTH`, default 1: payload width in bits, ≥1.
- `DEPTH`, default 2: storage entries; power of two, ≥2.
- `MODE`, default `HS_BUF_FALLTHROUGH`: `HS_BUF_FALLTHROUGH` bypasses storage when empty; `HS_BUF_REGISTERED` always drives `out` from storage.
- `AF_LEVEL`, default DEPTH-1: `almost_full` threshold, 1..DEPTH.
- `clk_core`, in, 1: single clock; all state updates on its rising edge.
- `rst_core_n`, in, 1: reset, synchronous, active-low.
- `flush_req`, in, 1: discard all buffered beats.
- `stall`, out, 1: equals `~in_ready`.
- `in`, in, WIDTH: upstream payload.
- `in_valid`, in, 1: upstream valid.
- `in_ready`, out, 1: upstream ready.
- `out`, out, WIDTH: downstream payload.
- `out_valid`, out, 1: downstream valid.
- `out_ready`, in, 1: downstream ready.
- `count`, out, $clog2(DEPTH+1): stored entries; excludes bypassed beats.
- `almost_full`, out, 1: asserted when `count >= AF_LEVEL`.

## Operation
- State:
  - `count` register.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits, with natural wrap-around at DEPTH.
  - Storage array, which is not reset.
- Handshake signals:
  - `in_ready = (count != DEPTH) & ~flush_req`. There is no combinational path from `out_ready` to `in_ready`.
  - push = `in_valid & in_ready`. pop = `out_valid & out_ready`.
- Fall-through mode, `count == 0`:
  - `out = in` and `out_valid = in_valid & ~flush_req`.
  - push & pop in the same cycle is a bypass: storage, pointers and `count` are unchanged.
  - push without pop writes `in` to storage.
- All other cases:
  - `out = mem[rd_ptr]` and `out_valid = (count != 0) & ~flush_req`.
  - push writes `mem[wr_ptr]` and increments `wr_ptr`.
  - pop increments `rd_ptr`.
  - `count` next value = `count + push − pop`. Simultaneous push & pop keeps `count` unchanged.
- Ordering: strict FIFO. A bypassed beat never overtakes a stored beat, because bypass is only possible when `count == 0`.
- Flush:
  - During a cycle with `flush_req`, no handshake completes on either side.
  - On the next edge, `count`, `wr_ptr` and `rd_ptr` all return to 0.
  - Beats presented in the flush cycle are dropped.
- Priority: reset > flush > normal operation.
- Upstream is required to hold `in` stable while `in_valid & ~in_ready`. This is not checked.

## Timing
- Reset values, from the edge where `rst_core_n = 0` is sampled:
  - `count = 0`, `in_ready = 1`, `stall = 0`, `almost_full = 0`.
  - `out_valid = 0` in registered mode; in fall-through mode `out_valid` follows `in_valid`.
- Reset asserted mid-operation discards all contents on that edge, exactly like a flush.
- Latency:
  - Fall-through mode: 0 cycles when empty; otherwise 1 cycle per queued entry ahead.
  - Registered mode: at least 1 cycle.
- Throughput: 1 beat/cycle sustained in both modes when `out_ready` is held high.
- Full (`count == DEPTH`): `in_ready` deasserts in the cycle after the filling push.
  - A pop in the full cycle does not admit a push in that same cycle; `in_ready` rises on the following cycle.
- Empty in registered mode: `out_valid` rises the cycle after the first push.
- `almost_full` and `count` are pure register outputs, updated on the edge after the push or pop.

## Structure
- Shared package `hs_utils_pkg` holds:
  - enum `hs_buf_mode_e` with values `HS_BUF_REGISTERED` and `HS_BUF_FALLTHROUGH`.
  - function `hs_cnt_w(depth)` returning $clog2(depth+1).
- Sub-module `hs_buf_mem`: DEPTH×WIDTH array with one synchronous write port and an asynchronous read port.
- Pointer/count control and output muxing stay in `hs_skid_fifo`.
- Elaboration checks:
  - DEPTH is a power of two and ≥2.
  - `AF_LEVEL` is in range 1..DEPTH.

## Test plan
- Reset: DEPTH=4, fall-through mode, `in_valid=1`, `in=0xA` while `rst_core_n=0` → `count=0` and `in_ready=1` after the edge; `out=0xA` and `out_valid=1` combinationally.
- Bypass: fall-through mode, empty, `out_ready=1`, stream 0x1..0x8 → `out` matches `in` in the same cycle and `count` stays 0 throughout.
- Backpressure fill: DEPTH=4, `out_ready=0`, push 0x1..0x6 → exactly 4 accepted, `in_ready=0` from cycle 5, `almost_full=1` at `count=3`. Then set `out_ready=1` → `out` yields 0x1, 0x2, 0x3, 0x4 in order, then 0x5 and 0x6.
- Registered mode: DEPTH=2, single push of 0x3 → `out_valid` rises exactly 1 cycle later with `out=0x3`. A continuous stream with `out_ready=1` sustains 1 beat/cycle.
- Flush: DEPTH=4, `count=3`, `flush_req` pulsed with `in_valid=1` and `out_ready=1` → no handshake in that cycle; next cycle `count=0`, `out_valid=0` (registered mode) and `in_ready=1`.
- Random: random `in_valid`/`out_ready`/`flush_req` for 10k cycles against a queue scoreboard → no loss, duplication or reordering outside flushes, and `count` always equals the model.
